tap_buffer_mc: RTL
==================

# tap_buffer_mc

Multi-channel, parametrised tap-delay buffer with valid/ready handshakes. It is the successor to the single-channel shift buffer. It accepts a time-interleaved sample stream, assigns samples to channels round-robin, and keeps a BufferSize-deep tap window per channel. After each accepted sample it emits that channel's full window as one flattened word, ready for the downstream multi-channel FIR/MAC stage.

## Interface
- DataBitWidth, 12, signed sample width
- BufferSize, 5, taps per channel (>=2)
- Channels, 2, number of interleaved channels (>=1)
- EmitPartial, 0, 1 = emit windows before a channel is full (unfilled taps read 0); 0 = emit full windows only
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  global enable; low blocks input acceptance
- flush  input  1  synchronous clear of taps, fill counters and channel pointer
- in_valid  input  1  d_in valid
- in_ready  output  1  block can accept d_in this cycle
- d_in  input  DataBitWidth  signed sample
- out_valid  output  1  d_out/out_ch valid
- out_ready  input  1  downstream accepts output
- out_ch  output  max(1,clog2(Channels))  channel of current window
- d_out  output  BufferSize*DataBitWidth  window; slice i = bits [i*DW+DW-1 : i*DW] = tap i, tap BufferSize-1 newest, tap 0 oldest

## Operation
- Storage: taps[Channels][BufferSize], fill[Channels] (saturating at BufferSize), channel pointer ptr (0..Channels-1), output register.
- in_ready = en & ~flush & (~out_valid | out_ready).
- Accept when in_valid & in_ready. Channel c = ptr:
  - taps[c][k] <= taps[c][k+1] for k = 0..BufferSize-2
  - taps[c][BufferSize-1] <= d_in
  - fill[c] increments, saturating at BufferSize
  - ptr advances, wrapping from Channels-1 to 0
  - other channels' taps are untouched
- Output load on accept: d_out <= post-shift window of c; out_ch <= c. out_valid <= 1 if EmitPartial=1 or post-increment fill[c] == BufferSize; otherwise out_valid <= 0.
- Output hold: when no accept, out_valid clears on out_ready; d_out and out_ch hold.
- Output when en is low: a pending output still completes on out_ready.
- Simultaneous out_ready and accept: the old window is consumed and the new window is loaded in the same edge, with no bubble.
- Flush:
  - zeroes all taps, fill counters, ptr, out_valid, d_out and out_ch
  - in_ready is low that cycle, so no sample is lost silently
  - takes priority over a simultaneous out_ready
- Data is passed through unmodified; no arithmetic and no width change.

## Timing
- Reset (rst low, asynchronous): taps = 0, fill = 0, ptr = 0, out_valid = 0, out_ch = 0, d_out = 0. in_ready follows its equation, so it is 1 when en = 1.
- Reset mid-operation: all state clears immediately; the first sample after release goes to channel 0.
- Latency: a sample accepted at edge t appears in d_out with out_valid high after edge t (one cycle).
- Throughput: one sample per cycle while out_ready is held high.
- Backpressure: with out_valid = 1 and out_ready = 0, in_ready = 0; d_out is stable until the handshake.
- First full-window output (EmitPartial=0): after accepted sample number Channels*(BufferSize-1)+1.

## Test plan
- Fill order (DW=8, BufferSize=3, Channels=2, out_ready=1, en=1): feed 1..7 on consecutive cycles.
  - out_valid is first high after sample 5, with out_ch=0 and d_out taps {2:5, 1:3, 0:1}.
  - Then out_ch=1 with {6,4,2}.
  - Then out_ch=0 with {7,5,3}.
- Backpressure: same stream with out_ready low for 3 cycles after the first output.
  - in_ready is low; d_out/out_ch stay at {5,3,1}/0.
  - After release the stream resumes with no loss or duplication.
- EmitPartial=1: feed 1 then 2.
  - Outputs are ch0 {1,0,0} then ch1 {2,0,0}, each one cycle after acceptance.
- Flush mid-stream: after samples 1..4, pulse flush together with in_valid.
  - in_ready is 0 that cycle and out_valid is 0 after it.
  - The next accepted sample, 9, goes to channel 0, and the first full window requires 5 further samples.
- Async reset mid-stream (rst low between edges): outputs zero immediately with no clock edge required; behaviour after release matches the fill-order test.
- en low with a pending output: out_valid and d_out hold; out_ready completes the transfer; no input is accepted until en returns high.

Source files
------------

// File: rtl/tap_buffer_mc.sv
// tap_buffer_mc
//   Multi-channel tap-delay buffer. A time-interleaved sample stream is split
//   across Channels round-robin. Each channel keeps a BufferSize-deep tap
//   window. After every accepted sample, that channel's window is presented
//   as one flattened word for a downstream multi-channel FIR/MAC stage.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   en         global enable; low blocks input acceptance
//   flush      synchronous clear of taps, fill counters, pointer and output
//   in_valid   d_in valid
//   in_ready   block can accept d_in this cycle
//   d_in       signed input sample
//   out_valid  d_out / out_ch valid
//   out_ready  downstream accepts the current window
//   out_ch     channel that the current window belongs to
//   d_out      window; slice i = tap i, tap BufferSize-1 newest, tap 0 oldest
module tap_buffer_mc #(
   parameter int DataBitWidth = 12,
   parameter int BufferSize   = 5,
   parameter int Channels     = 2,
   parameter int EmitPartial  = 0,
   localparam int ChW         = (Channels > 1) ? $clog2(Channels) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 en,
   input  logic                                 flush,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic signed [DataBitWidth-1:0]       d_in,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [ChW-1:0]                       out_ch,
   output logic [BufferSize*DataBitWidth-1:0]   d_out
);

   localparam int DW    = DataBitWidth;
   localparam int FillW = $clog2(BufferSize + 1);

   logic [DW-1:0]            taps [Channels][BufferSize];
   logic [FillW-1:0]         fill [Channels];
   logic [ChW-1:0]           ptr;

   logic                     accept;
   logic [BufferSize*DW-1:0] window_next;
   logic [FillW-1:0]         fill_next;
   logic [ChW-1:0]           ptr_next;
   logic                     emit;

   // A slot frees up either when nothing is pending or when the pending
   // window is being consumed this very edge, which gives full throughput.
   assign in_ready = en & ~flush & (~out_valid | out_ready);
   assign accept   = in_valid & in_ready;

   // Post-shift window of the channel being written, plus its updated
   // fill count and the next pointer value.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      window_next = '0;
      for (int k = 0; k < BufferSize - 1; k++) begin
         window_next[k*DW +: DW] = taps[ptr][k+1];
      end
      window_next[(BufferSize-1)*DW +: DW] = d_in;

      fill_next = (fill[ptr] == FillW'(BufferSize)) ? fill[ptr]
                                                    : fill[ptr] + FillW'(1);
      ptr_next  = (ptr == ChW'(Channels - 1)) ? '0 : ptr + ChW'(1);
      emit      = (EmitPartial != 0) || (fill_next == FillW'(BufferSize));
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the tap array is reset explicitly because unfilled taps are
         // observable as zero in emitted windows.
         for (int c = 0; c < Channels; c++) begin
            fill[c] <= '0;
            for (int k = 0; k < BufferSize; k++) begin
               taps[c][k] <= '0;
            end
         end
         ptr       <= '0;
         out_valid <= 1'b0;
         out_ch    <= '0;
         d_out     <= '0;
      end else if (flush) begin
         // Flush wins over a simultaneous out_ready; in_ready is low here so
         // no sample is dropped without the source seeing backpressure.
         for (int c = 0; c < Channels; c++) begin
            fill[c] <= '0;
            for (int k = 0; k < BufferSize; k++) begin
               taps[c][k] <= '0;
            end
         end
         ptr       <= '0;
         out_valid <= 1'b0;
         out_ch    <= '0;
         d_out     <= '0;
      end else if (accept) begin
         for (int k = 0; k < BufferSize; k++) begin
            taps[ptr][k] <= window_next[k*DW +: DW];
         end
         fill[ptr] <= fill_next;
         ptr       <= ptr_next;
         // The old window (if any) is consumed by out_ready in this same
         // edge, so the new one replaces it without a bubble.
         d_out     <= window_next;
         out_ch    <= ptr;
         out_valid <= emit;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
